// File: rtl/fetch_pkg.sv
// Shared types and default widths for the decoupled instruction-fetch front end.
package fetch_pkg;

   localparam int unsigned ImmWidth = 64;
   localparam int unsigned InstWidth = 32;
   localparam logic [ImmWidth-1:0] DefaultResetPc = 64'h8000_0000;

   typedef struct packed {
      logic [ImmWidth-1:0]  pc;
      logic [InstWidth-1:0] inst;
   } FetchEntry;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with push, pop and a clear that wins over a same-cycle push.
module fetch_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic                         pop,
   input  logic                         clear,
   input  logic [WIDTH-1:0]             wdata,
   output logic [WIDTH-1:0]             rdata,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PtrW-1:0]  wrPtr;
   logic [PtrW-1:0]  rdPtr;
   logic             full;
   logic             doPush;
   logic             doPop;

   assign empty  = (count == '0);
   assign full   = (count == CntW'(DEPTH));
   assign doPush = push && !full && !clear;
   assign doPop  = pop && !empty;
   assign rdata  = mem[rdPtr];

   always_ff @(posedge clk) begin
      if (doPush && !rst) begin
         mem[wrPtr] <= wdata;
      end
   end

   // DEPTH is a power of two, so pointers wrap naturally.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (doPush) begin
            wrPtr <= wrPtr + 1'b1;
         end
         if (doPop) begin
            rdPtr <= rdPtr + 1'b1;
         end
         count <= count + CntW'(doPush) - CntW'(doPop);
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Decoupled fetcher: credit-limited sequential requests, in-order response queue, redirect flush.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int unsigned      XLEN     = ImmWidth,
   parameter int unsigned      ILEN     = InstWidth,
   parameter int unsigned      DEPTH    = 4,
   parameter logic [XLEN-1:0]  RESET_PC = XLEN'(DefaultResetPc)
) (
   input  logic             clk,
   input  logic             rst,
   output logic             req_valid,
   input  logic             req_ready,
   output logic [XLEN-1:0]  req_addr,
   input  logic             resp_valid,
   input  logic [ILEN-1:0]  resp_inst,
   input  logic             redirect_valid,
   input  logic [XLEN-1:0]  redirect_pc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_pc,
   output logic [ILEN-1:0]  out_inst
);

   localparam int unsigned CntW = $clog2(DEPTH + 1);

   logic [XLEN-1:0]      fetchPc;
   logic [CntW-1:0]      dropCnt;
   logic [CntW-1:0]      inflight;
   logic [CntW-1:0]      inflightNext;
   logic [CntW-1:0]      count;
   logic [CntW:0]        credit;
   logic                 hs;
   logic                 respOk;
   logic                 respDrop;
   logic                 respKeep;
   logic                 popHead;
   logic                 pcEmpty;
   logic                 instEmpty;
   logic [XLEN-1:0]      respPc;
   logic [XLEN+ILEN-1:0] headData;

   // Issue is gated on outstanding + queued so every response has a free slot.
   assign credit    = {1'b0, inflight} + {1'b0, count};
   assign req_valid = !rst && (credit < (CntW + 1)'(DEPTH));
   assign req_addr  = fetchPc;
   assign hs        = req_valid && req_ready;

   // A response with nothing outstanding is a protocol error and is ignored.
   assign respOk   = resp_valid && !pcEmpty;
   assign respDrop = respOk && ((dropCnt != '0) || redirect_valid);
   assign respKeep = respOk && !respDrop;

   assign inflightNext = inflight + CntW'(hs) - CntW'(respOk);

   assign out_valid = !instEmpty;
   assign popHead   = out_valid && out_ready && !redirect_valid;
   assign out_pc    = headData[XLEN+ILEN-1:ILEN];
   assign out_inst  = headData[ILEN-1:0];

   // Occupancy of the PC FIFO is the in-flight request count.
   fetch_fifo #(
      .WIDTH (XLEN),
      .DEPTH (DEPTH)
   ) pcFifo (
      .clk   (clk),
      .rst   (rst),
      .push  (hs),
      .pop   (respOk),
      .clear (1'b0),
      .wdata (fetchPc),
      .rdata (respPc),
      .empty (pcEmpty),
      .count (inflight)
   );

   fetch_fifo #(
      .WIDTH (XLEN + ILEN),
      .DEPTH (DEPTH)
   ) instFifo (
      .clk   (clk),
      .rst   (rst),
      .push  (respKeep),
      .pop   (popHead),
      .clear (redirect_valid),
      .wdata ({respPc, resp_inst}),
      .rdata (headData),
      .empty (instEmpty),
      .count (count)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         fetchPc <= RESET_PC;
         dropCnt <= '0;
      end else if (redirect_valid) begin
         fetchPc <= redirect_pc & ~XLEN'(3);
         // Everything still outstanding after this edge, including a request
         // accepted this cycle, belongs to the old path.
         dropCnt <= inflightNext;
      end else begin
         if (hs) begin
            fetchPc <= fetchPc + XLEN'(4);
         end
         if (respDrop) begin
            dropCnt <= dropCnt - 1'b1;
         end
      end
   end

endmodule
